// File: rtl/fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction fetch stage. Owns the PC, issues word
//               fetches over a valid/ready request channel, buffers in-order
//               responses and hands {inst, inst_pc} to decode. Redirects
//               flush the stage and drain stale responses via a drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam int            CW       = $clog2(MAX_OUTSTANDING + 1);
    localparam int            IW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_OUTSTANDING - 1);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_count;
    logic [CW:0]   credits;

    // Instruction buffer and the PC tags of requests whose data will be kept
    logic [31:0]   buf_data [MAX_OUTSTANDING];
    logic [31:0]   buf_pc   [MAX_OUTSTANDING];
    logic [31:0]   tag_pc   [MAX_OUTSTANDING];
    logic [IW-1:0] buf_head;
    logic [IW-1:0] buf_tail;
    logic [IW-1:0] tag_head;
    logic [IW-1:0] tag_tail;

    logic          req_fire;
    logic          resp_ret;
    logic          resp_keep;
    logic          pop;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Responses seen while nothing is outstanding belong to pre-reset requests
    assign resp_ret  = imem_resp_valid && (outstanding != '0);
    assign resp_keep = resp_ret && (drop_cnt == '0) && !redirect;
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign pop       = inst_valid && inst_ready;
    assign credits   = {1'b0, outstanding} + {1'b0, buf_count};

    // Redirect never coincides with a request, so this also covers the redirect cycle
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_ret);

    assign imem_req_addr = pc;
    assign inst_valid    = (buf_count != '0);
    assign inst          = buf_data[buf_head];
    assign inst_pc       = buf_pc[buf_head];
    assign fetch_fault   = (state == FAULT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and request issue; a redirect always wins and suppresses requests
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        case (state)
            RUN:     imem_req_valid = rst_n && (credits < {1'b0, MAX_CNT}) && !redirect;
            FAULT:   imem_req_valid = 1'b0;
            default: state_next = RUN;
        endcase
        if (redirect) begin
            state_next = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
        end
    end

    // PC and credit counters; on redirect every still-outstanding response becomes a drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                pc       <= {redirect_pc[31:2], 2'b00};
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (resp_ret && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    // In-order tag queue: PC of each live request, consumed by its kept response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_head <= '0;
            tag_tail <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_pc[i] <= '0;
            end
        end else if (redirect) begin
            tag_head <= '0;
            tag_tail <= '0;
        end else begin
            if (req_fire) begin
                tag_pc[tag_tail] <= pc;
                tag_tail         <= ptr_inc(tag_tail);
            end
            if (resp_keep) begin
                tag_head <= ptr_inc(tag_head);
            end
        end
    end

    // Instruction buffer: circular FIFO, push and pop may coincide at any occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_head  <= '0;
            buf_tail  <= '0;
            buf_count <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (redirect) begin
            buf_head  <= '0;
            buf_tail  <= '0;
            buf_count <= '0;
        end else begin
            if (resp_keep) begin
                buf_data[buf_tail] <= imem_resp_data;
                buf_pc[buf_tail]   <= tag_pc[tag_head];
                buf_tail           <= ptr_inc(buf_tail);
            end
            if (pop) begin
                buf_head <= ptr_inc(buf_head);
            end
            buf_count <= buf_count + CW'(resp_keep) - CW'(pop);
        end
    end

    // Credit accounting must make a push into a full, non-draining buffer impossible
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(resp_keep && !pop && (buf_count == MAX_CNT)));
        end
    end

endmodule
`default_nettype wire
